// File: rtl/imem_pkg.sv
// Shared types and constants for the run-time loadable instruction memory.
package imem_pkg;

   typedef logic [31:0] instr_t;

   localparam instr_t NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } load_state_e;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x XLEN instruction array with independent synchronous write and
// synchronous read ports; every cell reads as NOP_INSTR until first written.
module imem_ram #(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     DEPTH     = 32,
   parameter logic [XLEN-1:0] NOP_INSTR = imem_pkg::NOP_INSTR,
   parameter int unsigned     AW        = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic            re,
   input  logic [AW-1:0]   raddr,
   output logic [XLEN-1:0] rdata
);
   import imem_pkg::*;

   // Cells hold (word ^ NOP_INSTR): zero power-up content reads back as NOP.
   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata ^ NOP_INSTR;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q ^ NOP_INSTR;

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with a one-cycle handshaked fetch port, fault detection
// and a streaming program-load port that rewrites the array from word 0.
module imem_loadable #(
   parameter int unsigned       XLEN      = 32,
   parameter int unsigned       DEPTH     = 32,
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [XLEN-1:0]   NOP_INSTR = imem_pkg::NOP_INSTR
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fetch_req,
   input  logic [ADDR_W-1:0]        fetch_addr,
   output logic                     fetch_ready,
   output logic                     fetch_valid,
   output logic [XLEN-1:0]          fetch_instr,
   output logic                     fetch_fault,
   input  logic                     load_start,
   input  logic                     load_valid,
   input  logic [XLEN-1:0]          load_data,
   input  logic                     load_last,
   output logic                     load_ready,
   output logic                     load_busy,
   output logic [$clog2(DEPTH):0]   load_count,
   output logic                     load_overflow
);
   import imem_pkg::*;

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;

   load_state_e       state_q, state_d;
   logic [CNT_W-1:0]  ptr_q, ptr_d;
   logic              overflow_q, overflow_d;
   logic              fetch_valid_q, fetch_valid_d;
   logic              fetch_fault_q, fetch_fault_d;
   logic              rd_ok_q, rd_ok_d;

   logic              fetch_acc;
   logic              addr_borrow;
   logic [ADDR_W-1:0] addr_off;
   logic [ADDR_W-1:0] word_idx;
   logic              addr_fault;
   logic              ram_we;
   logic              ram_re;
   logic [XLEN-1:0]   ram_rdata;

   assign fetch_ready = (state_q == ST_RUN);
   assign load_ready  = (state_q == ST_LOAD);
   assign load_busy   = (state_q == ST_LOAD) || (state_q == ST_DONE);
   assign fetch_acc   = fetch_req && fetch_ready;

   // Borrow out of the subtraction flags addresses below BASE_ADDR; the full
   // word index is range-checked so high address bits cannot alias low words.
   always_comb begin
      {addr_borrow, addr_off} = {1'b0, fetch_addr} - {1'b0, BASE_ADDR};
      word_idx   = addr_off >> 2;
      addr_fault = (fetch_addr[1:0] != 2'b00) || addr_borrow
                   || (word_idx >= ADDR_W'(DEPTH));
   end

   always_comb begin
      fetch_valid_d = fetch_acc;
      fetch_fault_d = fetch_acc ? addr_fault  : fetch_fault_q;
      rd_ok_d       = fetch_acc ? !addr_fault : rd_ok_q;
      ram_re        = fetch_acc && !addr_fault;
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      overflow_d = overflow_q;
      ram_we     = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (load_start) begin
               state_d    = ST_LOAD;
               ptr_d      = '0;
               overflow_d = 1'b0;
            end
         end
         ST_LOAD: begin
            if (load_valid) begin
               if (ptr_q < CNT_W'(DEPTH)) begin
                  ram_we = 1'b1;
                  ptr_d  = ptr_q + 1'b1;
               end else begin
                  overflow_d = 1'b1;
               end
               if (load_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         ptr_q         <= '0;
         overflow_q    <= 1'b0;
         fetch_valid_q <= 1'b0;
         fetch_fault_q <= 1'b0;
         rd_ok_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         overflow_q    <= overflow_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_fault_q <= fetch_fault_d;
         rd_ok_q       <= rd_ok_d;
      end
   end

   imem_ram #(
      .XLEN      (XLEN),
      .DEPTH     (DEPTH),
      .NOP_INSTR (NOP_INSTR),
      .AW        (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ptr_q[IDX_W-1:0]),
      .wdata (load_data),
      .re    (ram_re),
      .raddr (word_idx[IDX_W-1:0]),
      .rdata (ram_rdata)
   );

   // The read register only updates on good fetches, so a fault or reset
   // substitutes NOP here while the last good word stays in the RAM register.
   assign fetch_instr   = rd_ok_q ? ram_rdata : NOP_INSTR;
   assign fetch_valid   = fetch_valid_q;
   assign fetch_fault   = fetch_fault_q;
   assign load_count    = ptr_q;
   assign load_overflow = overflow_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: directed scenarios plus randomized load/fetch
// traffic, checked against an array model of the instruction memory.
module tb_imem_loadable;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned DEPTH  = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CW     = $clog2(DEPTH) + 1;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              reset;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_ready;
   logic              fetch_valid;
   logic [XLEN-1:0]   fetch_instr;
   logic              fetch_fault;
   logic              load_start;
   logic              load_valid;
   logic [XLEN-1:0]   load_data;
   logic              load_last;
   logic              load_ready;
   logic              load_busy;
   logic [CW-1:0]     load_count;
   logic              load_overflow;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] hold_instr;
   logic        hold_fault;
   logic [31:0] words [$];
   logic [31:0] addrs [$];

   imem_loadable #(
      .XLEN      (XLEN),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE),
      .NOP_INSTR (NOP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_req     (fetch_req),
      .fetch_addr    (fetch_addr),
      .fetch_ready   (fetch_ready),
      .fetch_valid   (fetch_valid),
      .fetch_instr   (fetch_instr),
      .fetch_fault   (fetch_fault),
      .load_start    (load_start),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_last     (load_last),
      .load_ready    (load_ready),
      .load_busy     (load_busy),
      .load_count    (load_count),
      .load_overflow (load_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chkc(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference: signed distance from BASE, word index = distance / 4.
   function automatic bit m_fault(input logic [31:0] a);
      longint d;
      d = longint'(a) - longint'(BASE);
      return (a[1:0] != 2'b00) || (d < 0) || (d / 4 >= longint'(DEPTH));
   endfunction

   function automatic logic [31:0] m_instr(input logic [31:0] a);
      int idx;
      if (m_fault(a)) return NOP;
      idx = int'((longint'(a) - longint'(BASE)) / 4);
      return model[idx];
   endfunction

   task automatic expect_resp(input logic [31:0] a, input string tag);
      hold_instr = m_instr(a);
      hold_fault = m_fault(a);
      chk1 ({tag, "_valid"}, fetch_valid, 1'b1);
      chk32({tag, "_instr"}, fetch_instr, hold_instr);
      chk1 ({tag, "_fault"}, fetch_fault, hold_fault);
   endtask

   // Back-to-back fetches of every address in addrs, then one idle cycle.
   task automatic fetch_burst(input string tag);
      foreach (addrs[k]) begin
         fetch_req  = 1'b1;
         fetch_addr = addrs[k];
         chk1({tag, "_ready"}, fetch_ready, 1'b1);
         tick();
         expect_resp(addrs[k], tag);
      end
      fetch_req = 1'b0;
      tick();
      chk1 ({tag, "_idle_valid"}, fetch_valid, 1'b0);
      chk32({tag, "_idle_instr"}, fetch_instr, hold_instr);
      chk1 ({tag, "_idle_fault"}, fetch_fault, hold_fault);
   endtask

   // Streams the words queue as one load; optionally holds a fetch request
   // from the load_start cycle until it is served after DONE.
   task automatic load_image(input bit gaps, input bit hold_fetch, input logic [31:0] fa);
      int n;
      int i;
      bit go;
      bit ovf;
      n   = words.size();
      i   = 0;
      ovf = 1'b0;
      if (hold_fetch) begin
         fetch_req  = 1'b1;
         fetch_addr = fa;
      end
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      if (hold_fetch) expect_resp(fa, "start_fetch");
      chkc("start_count", load_count, '0);
      chk1("start_ovf", load_overflow, 1'b0);
      while (i < n) begin
         go         = !gaps || ($urandom_range(2) != 0);
         load_valid = go;
         load_data  = words[i];
         load_last  = (i == n - 1);
         load_start = gaps ? 1'($urandom_range(1)) : 1'b0;
         chk1("ld_ready", load_ready, 1'b1);
         chk1("ld_busy", load_busy, 1'b1);
         chk1("ld_fetch_ready", fetch_ready, 1'b0);
         tick();
         if (go) begin
            if (i < int'(DEPTH)) model[i] = words[i];
            else ovf = 1'b1;
            i++;
         end
         chkc("ld_count", load_count, CW'((i < int'(DEPTH)) ? i : int'(DEPTH)));
         chk1("ld_ovf", load_overflow, ovf);
         chk1("ld_no_fetch_valid", fetch_valid, 1'b0);
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      load_start = gaps ? 1'($urandom_range(1)) : 1'b0;
      chk1("done_busy", load_busy, 1'b1);
      chk1("done_load_ready", load_ready, 1'b0);
      chk1("done_fetch_ready", fetch_ready, 1'b0);
      tick();
      load_start = 1'b0;
      chk1("run_busy", load_busy, 1'b0);
      chk1("run_fetch_ready", fetch_ready, 1'b1);
      chk1("run_load_ready", load_ready, 1'b0);
      chk1("run_no_valid", fetch_valid, 1'b0);
      chk1("run_ovf", load_overflow, ovf);
      if (hold_fetch) begin
         tick();
         fetch_req = 1'b0;
         expect_resp(fa, "post_done_fetch");
      end
   endtask

   task automatic rand_fetch(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         logic [31:0] a;
         bit          req;
         int          pick;
         pick = int'($urandom_range(7));
         if (pick < 6)       a = BASE + 32'($urandom_range(DEPTH - 1)) * 32'd4;
         else if (pick == 6) a = BASE + 32'($urandom_range(DEPTH * 4 - 1));
         else                a = $urandom;
         req        = ($urandom_range(3) != 0);
         fetch_req  = req;
         fetch_addr = a;
         chk1("rnd_ready", fetch_ready, 1'b1);
         tick();
         if (req) begin
            hold_instr = m_instr(a);
            hold_fault = m_fault(a);
         end
         chk1 ("rnd_valid", fetch_valid, req);
         chk32("rnd_instr", fetch_instr, hold_instr);
         chk1 ("rnd_fault", fetch_fault, hold_fault);
      end
      fetch_req = 1'b0;
   endtask

   initial begin
      reset      = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      for (int k = 0; k < int'(DEPTH); k++) model[k] = NOP;
      hold_instr = NOP;
      hold_fault = 1'b0;

      repeat (2) @(negedge clk);
      chk1 ("rst_valid", fetch_valid, 1'b0);
      chk1 ("rst_fault", fetch_fault, 1'b0);
      chk32("rst_instr", fetch_instr, NOP);
      chkc ("rst_count", load_count, '0);
      chk1 ("rst_ovf", load_overflow, 1'b0);
      chk1 ("rst_fetch_ready", fetch_ready, 1'b1);
      chk1 ("rst_load_ready", load_ready, 1'b0);
      chk1 ("rst_busy", load_busy, 1'b0);
      reset = 1'b1;
      tick();

      addrs = '{32'h0};
      fetch_burst("init_fetch");

      words = '{32'h0010_0193, 32'h0060_0293, 32'h0108_8933};
      load_image(1'b0, 1'b0, 32'h0);
      chkc("load3_count", load_count, CW'(3));
      addrs = '{32'h0, 32'h4, 32'h8};
      fetch_burst("load3_fetch");

      addrs = '{32'h6, 32'h80, 32'h4, 32'hFFFF_FFFC, 32'h7C};
      fetch_burst("fault_mix");

      words.delete();
      for (int k = 0; k < 34; k++) words.push_back($urandom);
      load_image(1'b0, 1'b0, 32'h0);
      chk1 ("ovf_set", load_overflow, 1'b1);
      chkc ("ovf_count", load_count, CW'(DEPTH));
      addrs = '{32'h7C};
      fetch_burst("ovf_last_word");
      chk32("ovf_word31", fetch_instr, words[31]);

      words = '{$urandom, $urandom};
      load_image(1'b0, 1'b1, 32'h4);

      words = '{$urandom, $urandom, $urandom, $urandom, $urandom};
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         load_valid = 1'b1;
         load_data  = words[k];
         tick();
         model[k] = words[k];
      end
      load_valid = 1'b0;
      chkc("mid_count", load_count, CW'(2));
      reset = 1'b0;
      #1;
      chkc ("midrst_count", load_count, '0);
      chk1 ("midrst_fetch_ready", fetch_ready, 1'b1);
      chk1 ("midrst_busy", load_busy, 1'b0);
      chk1 ("midrst_load_ready", load_ready, 1'b0);
      chk32("midrst_instr", fetch_instr, NOP);
      hold_instr = NOP;
      hold_fault = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      addrs = '{32'h0, 32'h4, 32'h8};
      fetch_burst("midrst_fetch");

      for (int r = 0; r < 4; r++) begin
         words.delete();
         for (int k = 0; k < int'($urandom_range(40, 1)); k++) words.push_back($urandom);
         load_image(1'b1, 1'($urandom_range(1)), BASE + 32'($urandom_range(DEPTH - 1)) * 32'd4);
         rand_fetch(60);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
